// File: rtl/ps2_kbd_pkg.sv
// Shared constants for the PS/2 keyboard controller: register map,
// STATUS/CTRL bit positions and the AXI response code.
package ps2_kbd_pkg;
  // Register selectors, decoded from addr[4:3]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  // DATA register
  localparam int DATA_VALID_BIT = 8;

  // STATUS sticky flag positions
  localparam int STATUS_OVF_BIT  = 16;
  localparam int STATUS_FERR_BIT = 17;
  localparam int STATUS_TMO_BIT  = 18;

  // CTRL bit positions
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_IRQEN_BIT = 1;
  localparam int CTRL_FLUSH_BIT = 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;
endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: line synchroniser, ps2_clk falling-edge detect,
// 11-bit shift/bit counter with frame check, and an inactivity watchdog.
// Outputs are single-cycle pulses.
module ps2_frame_rx #(
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable_i,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       code_valid_o,
  output logic [7:0] code_o,
  output logic       frame_err_o,
  output logic       timeout_o
);
  localparam int WDW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, dat_sync_q;
  logic                   clk_prev_q;
  logic                   fall, dat_s;
  logic [3:0]             bitcnt_q, bitcnt_d;
  logic [9:0]             bits_q, bits_d;
  logic [WDW-1:0]         wd_q, wd_d;
  logic                   code_valid_q, code_valid_d;
  logic                   frame_err_q, frame_err_d;
  logic                   timeout_q, timeout_d;
  logic [7:0]             code_q, code_d;

  // Synchronise both lines; idle-high reset value avoids a false edge
  always_ff @(posedge clock) begin
    if (!resetn) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
    end else begin
      clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
      dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], ps2_dat_i};
      clk_prev_q <= clk_sync_q[SYNC_STAGES-1];
    end
  end

  assign fall  = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];
  assign dat_s = dat_sync_q[SYNC_STAGES-1];

  // Bit collection, frame check at the 11th edge, and watchdog abort
  always_comb begin
    bitcnt_d     = bitcnt_q;
    bits_d       = bits_q;
    wd_d         = wd_q;
    code_d       = code_q;
    code_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    timeout_d    = 1'b0;
    if (!enable_i) begin
      bitcnt_d = 4'd0;
      wd_d     = '0;
    end else if (fall) begin
      wd_d = '0;
      if (bitcnt_q == 4'd10) begin
        // bits_q: [0]=start, [8:1]=data LSB first, [9]=parity; dat_s is stop
        bitcnt_d = 4'd0;
        if (!bits_q[0] && (^bits_q[9:1]) && dat_s) begin
          code_valid_d = 1'b1;
          code_d       = bits_q[8:1];
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        bits_d   = {dat_s, bits_q[9:1]};
        bitcnt_d = bitcnt_q + 4'd1;
      end
    end else if (bitcnt_q != 4'd0) begin
      if (wd_q == WD_LAST) begin
        bitcnt_d  = 4'd0;
        wd_d      = '0;
        timeout_d = 1'b1;
      end else begin
        wd_d = wd_q + WDW'(1);
      end
    end else begin
      wd_d = '0;
    end
  end

  // Receiver state and output pulse registers
  always_ff @(posedge clock) begin
    if (!resetn) begin
      bitcnt_q     <= 4'd0;
      bits_q       <= '0;
      wd_q         <= '0;
      code_q       <= 8'd0;
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      bitcnt_q     <= bitcnt_d;
      bits_q       <= bits_d;
      wd_q         <= wd_d;
      code_q       <= code_d;
      code_valid_q <= code_valid_d;
      frame_err_q  <= frame_err_d;
      timeout_q    <= timeout_d;
    end
  end

  assign code_valid_o = code_valid_q;
  assign code_o       = code_q;
  assign frame_err_o  = frame_err_q;
  assign timeout_o    = timeout_q;
endmodule

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 keyboard controller top: scan-code FIFO, sticky error flags,
// register file behind a single-beat AXI4 slave, and a level irq.
module ps2_kbd_ctrl
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH     = 16,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic        irq,
  input  logic        io_slave_awvalid,
  output logic        io_slave_awready,
  input  logic [31:0] io_slave_awaddr,
  input  logic [3:0]  io_slave_awid,
  input  logic [7:0]  io_slave_awlen,
  input  logic [2:0]  io_slave_awsize,
  input  logic [1:0]  io_slave_awburst,
  input  logic        io_slave_wvalid,
  output logic        io_slave_wready,
  input  logic [63:0] io_slave_wdata,
  input  logic [7:0]  io_slave_wstrb,
  input  logic        io_slave_wlast,
  output logic        io_slave_bvalid,
  input  logic        io_slave_bready,
  output logic [1:0]  io_slave_bresp,
  output logic [3:0]  io_slave_bid,
  input  logic        io_slave_arvalid,
  output logic        io_slave_arready,
  input  logic [31:0] io_slave_araddr,
  input  logic [3:0]  io_slave_arid,
  input  logic [7:0]  io_slave_arlen,
  input  logic [2:0]  io_slave_arsize,
  input  logic [1:0]  io_slave_arburst,
  output logic        io_slave_rvalid,
  input  logic        io_slave_rready,
  output logic [1:0]  io_slave_rresp,
  output logic [63:0] io_slave_rdata,
  output logic        io_slave_rlast,
  output logic [3:0]  io_slave_rid
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [0:0] RD_IDLE = 1'b0, RD_DATA = 1'b1;
  localparam logic [1:0] WR_ADDR_DATA = 2'd0, WR_COMMIT = 2'd1, WR_RESP = 2'd2;

  logic        rx_valid, rx_ferr, rx_tmo;
  logic [7:0]  rx_code;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] count_q;
  logic        ctrl_en_q, ctrl_irqen_q, ovf_q, ferr_q, tmo_q, irq_q;
  logic [0:0]  rd_state_q;
  logic [63:0] rdata_q;
  logic [3:0]  rid_q, awid_q;
  logic [1:0]  wr_state_q, wr_state_d, awsel_q;
  logic        aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        ar_hs, aw_hs, w_hs, pop, push, drop, full, flush;
  logic        wr_en, wr_status, wr_ctrl;
  logic [31:0] rd_word;
  logic        unused_ok;

  ps2_frame_rx #(.SYNC_STAGES(SYNC_STAGES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clock(clock), .resetn(resetn), .enable_i(ctrl_en_q),
    .ps2_clk_i(ps2_clk), .ps2_dat_i(ps2_dat),
    .code_valid_o(rx_valid), .code_o(rx_code),
    .frame_err_o(rx_ferr), .timeout_o(rx_tmo)
  );

  assign ar_hs     = io_slave_arvalid & io_slave_arready;
  assign aw_hs     = io_slave_awvalid & io_slave_awready;
  assign w_hs      = io_slave_wvalid & io_slave_wready;
  assign full      = (count_q == FULL_CNT);
  assign pop       = ar_hs & (io_slave_araddr[4:3] == REG_DATA) & (count_q != '0);
  assign wr_en     = (wr_state_q == WR_COMMIT) & (|wstrb_q);
  assign wr_status = wr_en & (awsel_q == REG_STATUS);
  assign wr_ctrl   = wr_en & (awsel_q == REG_CTRL);
  assign flush     = wr_ctrl & wdata_q[CTRL_FLUSH_BIT];
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign push      = rx_valid & ctrl_en_q & ~flush & (~full | pop);
  assign drop      = rx_valid & ctrl_en_q & ~flush & full & ~pop;

  // Register read mux, sampled at the AR handshake
  always_comb begin
    rd_word = 32'd0;
    case (io_slave_araddr[4:3])
      REG_DATA:   if (count_q != '0) rd_word = {23'd0, 1'b1, mem[rd_ptr_q]};
      REG_STATUS: rd_word = {13'd0, tmo_q, ferr_q, ovf_q, 16'(count_q)};
      REG_CTRL:   rd_word = {30'd0, ctrl_irqen_q, ctrl_en_q};
      default:    rd_word = 32'd0;
    endcase
  end

  // FIFO storage, written without reset so it maps onto RAM
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q] <= rx_code;
  end

  // FIFO pointers/occupancy, sticky flags, CTRL and irq
  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      ferr_q       <= 1'b0;
      tmo_q        <= 1'b0;
      ctrl_en_q    <= 1'b1;
      ctrl_irqen_q <= 1'b0;
      irq_q        <= 1'b0;
    end else begin
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        case ({push, pop})
          2'b10:   count_q <= count_q + (AW+1)'(1);
          2'b01:   count_q <= count_q - (AW+1)'(1);
          default: count_q <= count_q;
        endcase
      end
      // New events win over a simultaneous W1C so none is lost
      ovf_q  <= (ovf_q  & ~(wr_status & wdata_q[STATUS_OVF_BIT]))  | drop;
      ferr_q <= (ferr_q & ~(wr_status & wdata_q[STATUS_FERR_BIT])) | rx_ferr;
      tmo_q  <= (tmo_q  & ~(wr_status & wdata_q[STATUS_TMO_BIT]))  | rx_tmo;
      if (wr_ctrl) begin
        ctrl_en_q    <= wdata_q[CTRL_EN_BIT];
        ctrl_irqen_q <= wdata_q[CTRL_IRQEN_BIT];
      end
      irq_q <= ctrl_irqen_q & ((count_q != '0) | ovf_q | ferr_q | tmo_q);
    end
  end

  // Read channel FSM: capture data at AR handshake, hold until rready
  always_ff @(posedge clock) begin
    if (!resetn) begin
      rd_state_q <= RD_IDLE;
      rdata_q    <= 64'd0;
      rid_q      <= 4'd0;
    end else if (rd_state_q == RD_IDLE) begin
      if (ar_hs) begin
        rd_state_q <= RD_DATA;
        rdata_q    <= {32'd0, rd_word};
        rid_q      <= io_slave_arid;
      end
    end else if (io_slave_rready) begin
      rd_state_q <= RD_IDLE;
    end
  end

  // Write channel next state: AW and W collected independently
  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    case (wr_state_q)
      WR_ADDR_DATA: begin
        if ((aw_held_q | aw_hs) & (w_held_q | w_hs)) begin
          wr_state_d = WR_COMMIT;
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
        end else begin
          aw_held_d = aw_held_q | aw_hs;
          w_held_d  = w_held_q | w_hs;
        end
      end
      WR_COMMIT: wr_state_d = io_slave_bready ? WR_ADDR_DATA : WR_RESP;
      WR_RESP:   if (io_slave_bready) wr_state_d = WR_ADDR_DATA;
      default:   wr_state_d = WR_ADDR_DATA;
    endcase
  end

  // Write channel state and captured address/data
  always_ff @(posedge clock) begin
    if (!resetn) begin
      wr_state_q <= WR_ADDR_DATA;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awsel_q    <= 2'd0;
      awid_q     <= 4'd0;
      wdata_q    <= 32'd0;
      wstrb_q    <= 4'd0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      if (aw_hs) begin
        awsel_q <= io_slave_awaddr[4:3];
        awid_q  <= io_slave_awid;
      end
      if (w_hs) begin
        wdata_q <= io_slave_wdata[31:0];
        wstrb_q <= io_slave_wstrb[3:0];
      end
    end
  end

  assign io_slave_arready = (rd_state_q == RD_IDLE);
  assign io_slave_rvalid  = (rd_state_q == RD_DATA);
  assign io_slave_rlast   = io_slave_rvalid;
  assign io_slave_rresp   = RESP_OKAY;
  assign io_slave_rdata   = rdata_q;
  assign io_slave_rid     = rid_q;
  assign io_slave_awready = (wr_state_q == WR_ADDR_DATA) & ~aw_held_q;
  assign io_slave_wready  = (wr_state_q == WR_ADDR_DATA) & ~w_held_q;
  assign io_slave_bvalid  = (wr_state_q == WR_COMMIT) | (wr_state_q == WR_RESP);
  assign io_slave_bresp   = RESP_OKAY;
  assign io_slave_bid     = awid_q;
  assign irq              = irq_q;

  // Single-beat slave: burst fields and unmapped address/data bits are ignored
  assign unused_ok = ^{io_slave_awaddr[31:5], io_slave_awaddr[2:0], io_slave_awlen,
                       io_slave_awsize, io_slave_awburst, io_slave_wdata[63:32],
                       io_slave_wstrb[7:4], io_slave_wlast, io_slave_araddr[31:5],
                       io_slave_araddr[2:0], io_slave_arlen, io_slave_arsize,
                       io_slave_arburst, wdata_q};
endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: register table plus PS/2 frame sequences.
module tb_ps2_kbd_ctrl;
  localparam int DEPTH = 8;
  localparam int SYNC  = 3;
  localparam int TMO   = 200;
  localparam int H     = 10;  // PS/2 half bit period in system clocks

  logic        clock, resetn, ps2_clk, ps2_dat, irq;
  logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, rlast;
  logic [31:0] awaddr, araddr;
  logic [3:0]  awid, arid, bid, rid;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [63:0] wdata, rdata;

  ps2_kbd_ctrl #(.FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .resetn(resetn), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat), .irq(irq),
    .io_slave_awvalid(awvalid), .io_slave_awready(awready), .io_slave_awaddr(awaddr),
    .io_slave_awid(awid), .io_slave_awlen(awlen), .io_slave_awsize(awsize),
    .io_slave_awburst(awburst), .io_slave_wvalid(wvalid), .io_slave_wready(wready),
    .io_slave_wdata(wdata), .io_slave_wstrb(wstrb), .io_slave_wlast(wlast),
    .io_slave_bvalid(bvalid), .io_slave_bready(bready), .io_slave_bresp(bresp),
    .io_slave_bid(bid), .io_slave_arvalid(arvalid), .io_slave_arready(arready),
    .io_slave_araddr(araddr), .io_slave_arid(arid), .io_slave_arlen(arlen),
    .io_slave_arsize(arsize), .io_slave_arburst(arburst), .io_slave_rvalid(rvalid),
    .io_slave_rready(rready), .io_slave_rresp(rresp), .io_slave_rdata(rdata),
    .io_slave_rlast(rlast), .io_slave_rid(rid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] next_id = 4'd1;

  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  strb;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, act);
    end
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] code, input logic bad_par,
                                           input logic bad_stop);
    return {~bad_stop, (~^code) ^ bad_par, code, 1'b0};
  endfunction

  // All tasks start and end just after a falling system-clock edge
  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    repeat (H) @(negedge clock);
    ps2_clk = 1'b0;
    repeat (H) @(negedge clock);
    ps2_clk = 1'b1;
  endtask

  task automatic send_bits(input logic [10:0] fr, input int n);
    for (int i = 0; i < n; i++) ps2_bit(fr[i]);
    ps2_dat = 1'b1;
    repeat (4*H) @(negedge clock);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [63:0] data);
    int cnt;
    logic [3:0] id;
    id = next_id;
    next_id = next_id + 4'd1;
    arvalid = 1'b1; araddr = addr; arid = id; cnt = 0;
    while (!arready && cnt < 50) begin @(negedge clock); cnt++; end
    @(negedge clock);
    arvalid = 1'b0;
    cnt = 0;
    while (!rvalid && cnt < 50) begin @(negedge clock); cnt++; end
    if (!rvalid) begin
      n_checks++; n_fail++;
      $display("FAIL rd_timeout addr 0x%0h: rvalid=0, required 1", addr);
      data = '0;
    end else begin
      data = rdata;
      check($sformatf("rd 0x%0h rid", addr), {60'd0, rid}, {60'd0, id});
      check($sformatf("rd 0x%0h rresp/rlast", addr), {61'd0, rresp, rlast}, {61'd0, 2'b00, 1'b1});
    end
    @(negedge clock);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [7:0] strb);
    int cnt;
    logic [3:0] id;
    logic aw_hs, w_hs;
    id = next_id;
    next_id = next_id + 4'd1;
    awvalid = 1'b1; awaddr = addr; awid = id;
    wvalid = 1'b1; wdata = {32'hDEAD_BEEF, data}; wstrb = strb;
    cnt = 0;
    while ((awvalid || wvalid) && cnt < 50) begin
      aw_hs = awvalid & awready;
      w_hs  = wvalid & wready;
      @(negedge clock);
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
      cnt++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    cnt = 0;
    while (!bvalid && cnt < 50) begin @(negedge clock); cnt++; end
    if (!bvalid) begin
      n_checks++; n_fail++;
      $display("FAIL wr_timeout addr 0x%0h: bvalid=0, required 1", addr);
    end else begin
      check($sformatf("wr 0x%0h bid/bresp", addr), {58'd0, bid, bresp}, {58'd0, id, 2'b00});
    end
    @(negedge clock);
  endtask

  task automatic rd_check(input string name, input logic [31:0] addr, input logic [31:0] exp);
    logic [63:0] d;
    axi_read(addr, d);
    check(name, d, {32'd0, exp});
  endtask

  initial begin
    logic [63:0] d;
    logic [10:0] fr;
    logic [7:0]  codes [DEPTH+1];

    resetn = 1'b0; ps2_clk = 1'b1; ps2_dat = 1'b1;
    awvalid = 0; awaddr = 0; awid = 0; awlen = 0; awsize = 3'd3; awburst = 2'd1;
    wvalid = 0; wdata = 0; wstrb = 0; wlast = 1'b1; bready = 1'b1;
    arvalid = 0; araddr = 0; arid = 0; arlen = 0; arsize = 3'd3; arburst = 2'd1; rready = 1'b1;
    repeat (5) @(negedge clock);
    resetn = 1'b1;
    @(negedge clock);

    // Reset state of the interface
    check("reset ready/valid/irq", {58'd0, arready, awready, wready, rvalid, bvalid, irq},
          {58'd0, 6'b111000});
    check("reset rdata", rdata, 64'd0);
    check("reset rid/bid", {56'd0, rid, bid}, 64'd0);

    // Register-level vectors
    tbl[0]  = '{1'b0, 8'h08, 32'h0,        8'h00, 32'h0};
    tbl[1]  = '{1'b0, 8'h10, 32'h0,        8'h00, 32'h1};
    tbl[2]  = '{1'b0, 8'h00, 32'h0,        8'h00, 32'h0};
    tbl[3]  = '{1'b0, 8'h18, 32'h0,        8'h00, 32'h0};
    tbl[4]  = '{1'b1, 8'h18, 32'hFFFFFFFF, 8'hFF, 32'h0};
    tbl[5]  = '{1'b0, 8'h18, 32'h0,        8'h00, 32'h0};
    tbl[6]  = '{1'b1, 8'h10, 32'h3,        8'h0F, 32'h0};
    tbl[7]  = '{1'b0, 8'h10, 32'h0,        8'h00, 32'h3};
    tbl[8]  = '{1'b1, 8'h10, 32'h0,        8'hF0, 32'h0};
    tbl[9]  = '{1'b0, 8'h10, 32'h0,        8'h00, 32'h3};
    tbl[10] = '{1'b1, 8'h10, 32'h1,        8'h01, 32'h0};
    tbl[11] = '{1'b0, 8'h10, 32'h0,        8'h00, 32'h1};
    tbl[12] = '{1'b0, 8'h08, 32'h0,        8'h00, 32'h0};
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].wr) begin
        axi_write({24'd0, tbl[i].addr}, tbl[i].wdata, tbl[i].strb);
      end else begin
        axi_read({24'd0, tbl[i].addr}, d);
        check($sformatf("vec%0d rd 0x%0h", i, tbl[i].addr), d, {32'd0, tbl[i].exp});
      end
    end

    // Good frame 0x1C
    send_bits(mk_frame(8'h1C, 1'b0, 1'b0), 11);
    rd_check("0x1C STATUS", 32'h08, 32'h1);
    rd_check("0x1C DATA", 32'h00, 32'h11C);
    rd_check("empty DATA", 32'h00, 32'h0);

    // Bad parity then bad stop
    send_bits(mk_frame(8'h33, 1'b1, 1'b0), 11);
    send_bits(mk_frame(8'h44, 1'b0, 1'b1), 11);
    rd_check("frame_err STATUS", 32'h08, 32'h20000);
    axi_write(32'h08, 32'h20000, 8'h0F);
    rd_check("frame_err cleared", 32'h08, 32'h0);

    // Partial frame then watchdog
    send_bits(mk_frame(8'h5A, 1'b0, 1'b0), 6);
    repeat (TMO + 20) @(negedge clock);
    rd_check("timeout STATUS", 32'h08, 32'h40000);
    axi_write(32'h08, 32'h40000, 8'h0F);
    send_bits(mk_frame(8'h5A, 1'b0, 1'b0), 11);
    rd_check("after timeout STATUS", 32'h08, 32'h1);
    rd_check("after timeout DATA", 32'h00, 32'h15A);

    // Receiver disabled: frame ignored
    axi_write(32'h10, 32'h0, 8'h0F);
    send_bits(mk_frame(8'h66, 1'b0, 1'b0), 11);
    rd_check("disabled STATUS", 32'h08, 32'h0);

    // Overflow with irq enabled
    axi_write(32'h10, 32'h3, 8'h0F);
    check("irq idle", {63'd0, irq}, 64'd0);
    for (int i = 0; i <= DEPTH; i++) begin
      codes[i] = 8'h21 + 8'(i * 19);
      send_bits(mk_frame(codes[i], 1'b0, 1'b0), 11);
    end
    rd_check("overflow STATUS", 32'h08, 32'h10000 | DEPTH);
    check("irq full", {63'd0, irq}, 64'd1);
    for (int i = 0; i < DEPTH; i++)
      rd_check($sformatf("drain %0d", i), 32'h00, {23'd0, 1'b1, codes[i]});
    repeat (2) @(negedge clock);
    check("irq overflow only", {63'd0, irq}, 64'd1);
    axi_write(32'h08, 32'h10000, 8'h0F);
    repeat (2) @(negedge clock);
    check("irq cleared", {63'd0, irq}, 64'd0);

    // Pop coinciding with push into a full FIFO
    for (int i = 0; i < DEPTH; i++) send_bits(mk_frame(8'h40 + 8'(i), 1'b0, 1'b0), 11);
    rd_check("full again", 32'h08, DEPTH);
    fr = mk_frame(8'h99, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) ps2_bit(fr[i]);
    ps2_dat = fr[10];
    repeat (H) @(negedge clock);
    ps2_clk = 1'b0;
    repeat (SYNC + 1) @(negedge clock);
    axi_read(32'h00, d);
    check("coincident pop", d, 64'h140);
    ps2_clk = 1'b1;
    repeat (2*H) @(negedge clock);
    rd_check("coincident STATUS", 32'h08, DEPTH);
    for (int i = 1; i < DEPTH; i++)
      rd_check($sformatf("post drain %0d", i), 32'h00, 32'h140 + i);
    rd_check("post drain last", 32'h00, 32'h199);

    // Flush with entries queued
    for (int i = 0; i < 3; i++) send_bits(mk_frame(8'h70 + 8'(i), 1'b0, 1'b0), 11);
    rd_check("pre flush", 32'h08, 32'h3);
    axi_write(32'h10, 32'h5, 8'h0F);
    rd_check("post flush STATUS", 32'h08, 32'h0);
    rd_check("post flush CTRL", 32'h10, 32'h1);

    // Read back-pressure
    send_bits(mk_frame(8'h77, 1'b0, 1'b0), 11);
    rready = 1'b0; arvalid = 1'b1; araddr = 32'h00; arid = 4'hA;
    @(negedge clock);
    arvalid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("stall %0d rvalid/arready/rdata", k), {rdata[61:0], rvalid, arready},
            {62'h177, 1'b1, 1'b0});
      @(negedge clock);
    end
    rready = 1'b1;
    @(negedge clock);
    check("after R hs rvalid/arready", {62'd0, rvalid, arready}, {62'd0, 2'b01});
    rd_check("stall popped", 32'h08, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
